// File: rtl/noc_pkg.sv
// Shared NoC definitions for the PE network interface.
// Holds the packet width, the bit offsets of every packet field, the packed
// packet struct and the RX holding-register FSM state type.
//
// Packet layout (33 bits):
//   [32:31] dst_x   [30:29] dst_y   [28:27] src_x   [26:25] src_y   [24:0] payload
package noc_pkg;

    localparam int PKT_W       = 33;
    localparam int COORD_W     = 2;
    localparam int PAYLOAD_W   = 25;

    localparam int DST_X_LSB   = 31;
    localparam int DST_Y_LSB   = 29;
    localparam int SRC_X_LSB   = 27;
    localparam int SRC_Y_LSB   = 25;
    localparam int PAYLOAD_LSB = 0;

    typedef struct packed {
        logic [COORD_W-1:0]   dst_x;
        logic [COORD_W-1:0]   dst_y;
        logic [COORD_W-1:0]   src_x;
        logic [COORD_W-1:0]   src_y;
        logic [PAYLOAD_W-1:0] payload;
    } noc_pkt_t;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo -- small synchronous valid/ready queue used as the NI TX buffer.
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries (power of two, at least 2)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   write side; push when both high at a rising edge
//   in_data               entry to push
//   out_valid / out_ready read side; pop when both high at a rising edge
//   out_data              current head entry (0 while empty)
//
// Pointers wrap naturally modulo DEPTH; an occupancy counter one bit wider
// than the pointers tells full from empty. in_ready depends only on the
// occupancy, so a push while full is simply not accepted even if a pop
// happens in the same cycle.
module ni_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Head is masked so the data output reads 0 whenever nothing is queued.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/pe_net_interface.sv
// pe_net_interface -- network interface between a processing element and
// the PE port of its mesh router.
//
// TX: PE requests are packetized with this node's address as source and
// queued in ni_fifo; the queue head is offered to the router.
// RX: a 2-state (EMPTY/FULL) FSM with a 1-entry holding register accepts
// packets from the router; packets not addressed to this node are dropped.
// Packets the PE sends to its own address go out to the network like any
// other (no internal loopback).
//
// Parameters: WIDTH (packet bits), ADDR_X/ADDR_Y (node coordinates),
//             DEPTH (TX FIFO entries).
// Ports:
//   clk, rst_n                                  clock, async active-low reset
//   pe_tx_valid/ready, pe_tx_dst_x/y, pe_tx_data  PE injection requests
//   net_tx_valid/ready, net_tx_pkt               packets to the router
//   net_rx_valid/ready, net_rx_pkt               packets from the router
//   pe_rx_valid/ready, pe_rx_src_x/y, pe_rx_data  delivery to the PE
//   tx_count, rx_count, drop_count               saturating statistics,
//                                                present only with NI_STATS_EN
module pe_net_interface
    import noc_pkg::*;
#(
    parameter int         WIDTH  = PKT_W,
    parameter logic [1:0] ADDR_X = 2'b00,
    parameter logic [1:0] ADDR_Y = 2'b00,
    parameter int         DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pe_tx_valid,
    output logic             pe_tx_ready,
    input  logic [1:0]       pe_tx_dst_x,
    input  logic [1:0]       pe_tx_dst_y,
    input  logic [24:0]      pe_tx_data,
    output logic             net_tx_valid,
    input  logic             net_tx_ready,
    output logic [WIDTH-1:0] net_tx_pkt,
    input  logic             net_rx_valid,
    output logic             net_rx_ready,
    input  logic [WIDTH-1:0] net_rx_pkt,
    output logic             pe_rx_valid,
    input  logic             pe_rx_ready,
    output logic [1:0]       pe_rx_src_x,
    output logic [1:0]       pe_rx_src_y,
    output logic [24:0]      pe_rx_data
`ifdef NI_STATS_EN
    ,
    output logic [15:0]      tx_count,
    output logic [15:0]      rx_count,
    output logic [15:0]      drop_count
`endif
);

    // Low during reset and set by the first clock edge after release, so
    // no ready is offered before that edge.
    logic init_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_done <= 1'b0;
        else        init_done <= 1'b1;
    end

    // ---------------- TX path ----------------
    noc_pkt_t tx_pkt;
    logic     fifo_in_ready;

    always_comb begin
        tx_pkt.dst_x   = pe_tx_dst_x;
        tx_pkt.dst_y   = pe_tx_dst_y;
        tx_pkt.src_x   = ADDR_X;
        tx_pkt.src_y   = ADDR_Y;
        tx_pkt.payload = pe_tx_data;
    end

    assign pe_tx_ready = init_done && fifo_in_ready;

    ni_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pe_tx_valid && init_done),
        .in_ready  (fifo_in_ready),
        .in_data   (WIDTH'(tx_pkt)),
        .out_valid (net_tx_valid),
        .out_ready (net_tx_ready),
        .out_data  (net_tx_pkt)
    );

    // ---------------- RX path ----------------
    noc_pkt_t  rx_in;
    noc_pkt_t  held;
    rx_state_t state;
    rx_state_t state_next;
    logic      rx_accept;
    logic      rx_match;
    logic      pe_accept;

    assign rx_in     = noc_pkt_t'(net_rx_pkt[PKT_W-1:0]);
    assign rx_match  = (rx_in.dst_x == ADDR_X) && (rx_in.dst_y == ADDR_Y);
    assign rx_accept = net_rx_valid && net_rx_ready;
    assign pe_accept = pe_rx_valid && pe_rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_EMPTY: if (rx_accept && rx_match) state_next = RX_FULL;
            RX_FULL:  if (pe_accept)             state_next = RX_EMPTY;
            default:                             state_next = RX_EMPTY;
        endcase
    end

    always_comb begin
        net_rx_ready = 1'b0;
        pe_rx_valid  = 1'b0;
        case (state)
            RX_EMPTY: net_rx_ready = init_done;
            RX_FULL:  pe_rx_valid  = 1'b1;
            default: ;
        endcase
    end

    // Holding register; ready is low in FULL so a capture can only occur in EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     held <= '0;
        else if (rx_accept && rx_match) held <= rx_in;
    end

    assign pe_rx_src_x = held.src_x;
    assign pe_rx_src_y = held.src_y;
    assign pe_rx_data  = held.payload;

`ifdef NI_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count   <= '0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (net_tx_valid && net_tx_ready) tx_count   <= sat_inc(tx_count);
            if (pe_accept)                    rx_count   <= sat_inc(rx_count);
            if (rx_accept && !rx_match)       drop_count <= sat_inc(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_pe_net_interface.sv
// Directed bench for pe_net_interface at node ADDR 01/10, DEPTH 4.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// Statistics checks are compiled in when NI_STATS_EN is defined.
module tb_pe_net_interface;

    localparam int W = 33;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pe_tx_valid;
    logic          pe_tx_ready;
    logic [1:0]    pe_tx_dst_x;
    logic [1:0]    pe_tx_dst_y;
    logic [24:0]   pe_tx_data;
    logic          net_tx_valid;
    logic          net_tx_ready;
    logic [W-1:0]  net_tx_pkt;
    logic          net_rx_valid;
    logic          net_rx_ready;
    logic [W-1:0]  net_rx_pkt;
    logic          pe_rx_valid;
    logic          pe_rx_ready;
    logic [1:0]    pe_rx_src_x;
    logic [1:0]    pe_rx_src_y;
    logic [24:0]   pe_rx_data;
`ifdef NI_STATS_EN
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;
    logic [15:0]   drop_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_net_interface #(
        .WIDTH  (W),
        .ADDR_X (2'b01),
        .ADDR_Y (2'b10),
        .DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pe_tx_valid  (pe_tx_valid),
        .pe_tx_ready  (pe_tx_ready),
        .pe_tx_dst_x  (pe_tx_dst_x),
        .pe_tx_dst_y  (pe_tx_dst_y),
        .pe_tx_data   (pe_tx_data),
        .net_tx_valid (net_tx_valid),
        .net_tx_ready (net_tx_ready),
        .net_tx_pkt   (net_tx_pkt),
        .net_rx_valid (net_rx_valid),
        .net_rx_ready (net_rx_ready),
        .net_rx_pkt   (net_rx_pkt),
        .pe_rx_valid  (pe_rx_valid),
        .pe_rx_ready  (pe_rx_ready),
        .pe_rx_src_x  (pe_rx_src_x),
        .pe_rx_src_y  (pe_rx_src_y),
        .pe_rx_data   (pe_rx_data)
`ifdef NI_STATS_EN
        ,
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .drop_count   (drop_count)
`endif
    );

    // Packet as this node (src 01/10) builds it.
    function automatic logic [W-1:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                        input logic [24:0] d);
        return {dx, dy, 2'b01, 2'b10, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        pe_tx_valid  = 1'b0;
        pe_tx_dst_x  = 2'b00;
        pe_tx_dst_y  = 2'b00;
        pe_tx_data   = '0;
        net_tx_ready = 1'b0;
        net_rx_valid = 1'b0;
        net_rx_pkt   = '0;
        pe_rx_ready  = 1'b0;

        // Reset state
        #3;
        chk("rst_pe_tx_ready", 64'(pe_tx_ready), 64'd0);
        chk("rst_net_tx_valid", 64'(net_tx_valid), 64'd0);
        chk("rst_net_rx_ready", 64'(net_rx_ready), 64'd0);
        chk("rst_pe_rx_valid", 64'(pe_rx_valid), 64'd0);
        chk("rst_net_tx_pkt", 64'(net_tx_pkt), 64'd0);
        chk("rst_pe_rx_data", 64'(pe_rx_data), 64'd0);
        tick();
        chk("rst_hold_ready", 64'(pe_tx_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("pre_edge_ready", 64'(pe_tx_ready), 64'd0);
        tick();
        chk("post_rst_tx_ready", 64'(pe_tx_ready), 64'd1);
        chk("post_rst_rx_ready", 64'(net_rx_ready), 64'd1);

        // Packetize: dst 11/00, data 1ABCD, visible one cycle after push
        pe_tx_valid = 1'b1;
        pe_tx_dst_x = 2'b11;
        pe_tx_dst_y = 2'b00;
        pe_tx_data  = 25'h1ABCD;
        chk("pkt_pre_valid", 64'(net_tx_valid), 64'd0);
        tick();
        pe_tx_valid = 1'b0;
        chk("pkt_valid", 64'(net_tx_valid), 64'd1);
        chk("pkt_value", 64'(net_tx_pkt), 64'({2'b11, 2'b00, 2'b01, 2'b10, 25'h1ABCD}));
        net_tx_ready = 1'b1;
        tick();
        net_tx_ready = 1'b0;
        chk("pkt_drained", 64'(net_tx_valid), 64'd0);

        // Backpressure: 4 accepted, 5th held off
        for (int i = 0; i < 4; i++) begin
            pe_tx_valid = 1'b1;
            pe_tx_dst_x = 2'(i);
            pe_tx_dst_y = 2'(3 - i);
            pe_tx_data  = 25'h100 + 25'(i);
            chk("fill_ready", 64'(pe_tx_ready), 64'd1);
            tick();
        end
        chk("full_ready_low", 64'(pe_tx_ready), 64'd0);
        chk("full_count", 64'(dut.u_fifo.count), 64'd4);
        chk("full_head", 64'(net_tx_pkt), 64'(mk(2'd0, 2'd3, 25'h100)));
        pe_tx_dst_x = 2'b10;
        pe_tx_dst_y = 2'b01;
        pe_tx_data  = 25'h1FFFFFF;
        tick();
        chk("fifth_blocked_ready", 64'(pe_tx_ready), 64'd0);
        chk("fifth_blocked_count", 64'(dut.u_fifo.count), 64'd4);

        // Pop while full with ready low: occupancy drops to 3, push follows
        net_tx_ready = 1'b1;
        tick();
        chk("pop_full_count", 64'(dut.u_fifo.count), 64'd3);
        chk("pop_full_ready", 64'(pe_tx_ready), 64'd1);
        net_tx_ready = 1'b0;
        tick();
        pe_tx_valid = 1'b0;
        chk("late_push_count", 64'(dut.u_fifo.count), 64'd4);
        chk("late_push_ready", 64'(pe_tx_ready), 64'd0);

        net_tx_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("drain_valid", 64'(net_tx_valid), 64'd1);
            chk("drain_order", 64'(net_tx_pkt), 64'(mk(2'(k), 2'(3 - k), 25'h100 + 25'(k))));
            tick();
        end
        chk("drain_last", 64'(net_tx_pkt), 64'(mk(2'b10, 2'b01, 25'h1FFFFFF)));
        tick();
        chk("drain_empty", 64'(net_tx_valid), 64'd0);
        chk("drain_count", 64'(dut.u_fifo.count), 64'd0);
        net_tx_ready = 1'b0;

        // Self-addressed packet goes to the network, not to the PE
        pe_tx_valid = 1'b1;
        pe_tx_dst_x = 2'b01;
        pe_tx_dst_y = 2'b10;
        pe_tx_data  = 25'h0AA;
        tick();
        pe_tx_valid = 1'b0;
        chk("self_net_pkt", 64'(net_tx_pkt), 64'(mk(2'b01, 2'b10, 25'h0AA)));
        chk("self_no_loop", 64'(pe_rx_valid), 64'd0);
        net_tx_ready = 1'b1;
        tick();
        net_tx_ready = 1'b0;
        chk("self_drained", 64'(net_tx_valid), 64'd0);
        chk("self_no_loop2", 64'(pe_rx_valid), 64'd0);

        // RX delivery: dst 01/10, src 00/11, data 5
        net_rx_valid = 1'b1;
        net_rx_pkt   = {2'b01, 2'b10, 2'b00, 2'b11, 25'h5};
        chk("rx_ready_empty", 64'(net_rx_ready), 64'd1);
        tick();
        net_rx_pkt   = {2'b01, 2'b10, 2'b11, 2'b01, 25'h7};
        chk("rx_valid", 64'(pe_rx_valid), 64'd1);
        chk("rx_src_x", 64'(pe_rx_src_x), 64'd0);
        chk("rx_src_y", 64'(pe_rx_src_y), 64'd3);
        chk("rx_data", 64'(pe_rx_data), 64'd5);
        chk("rx_ready_full", 64'(net_rx_ready), 64'd0);
        tick();
        chk("rx_hold_valid", 64'(pe_rx_valid), 64'd1);
        chk("rx_hold_data", 64'(pe_rx_data), 64'd5);
        chk("rx_hold_ready", 64'(net_rx_ready), 64'd0);
        pe_rx_ready = 1'b1;
        tick();
        pe_rx_ready = 1'b0;
        chk("rx_after_accept_valid", 64'(pe_rx_valid), 64'd0);
        chk("rx_after_accept_ready", 64'(net_rx_ready), 64'd1);
        tick();
        net_rx_valid = 1'b0;
        chk("rx2_data", 64'(pe_rx_data), 64'd7);
        chk("rx2_src_x", 64'(pe_rx_src_x), 64'd3);
        pe_rx_ready = 1'b1;
        tick();
        pe_rx_ready = 1'b0;
        chk("rx2_done", 64'(pe_rx_valid), 64'd0);

        // Misrouted packet (dst 10/10) is accepted and dropped
        net_rx_valid = 1'b1;
        net_rx_pkt   = {2'b10, 2'b10, 2'b00, 2'b00, 25'h9};
        chk("drop_ready", 64'(net_rx_ready), 64'd1);
        tick();
        net_rx_valid = 1'b0;
        chk("drop_no_valid", 64'(pe_rx_valid), 64'd0);
        chk("drop_still_empty", 64'(net_rx_ready), 64'd1);
`ifdef NI_STATS_EN
        chk("stat_drop", 64'(drop_count), 64'd1);
        chk("stat_rx", 64'(rx_count), 64'd2);
        chk("stat_tx", 64'(tx_count), 64'd7);
`endif

        // Reset mid-traffic: 3 queued, 1 held
        for (int i = 0; i < 3; i++) begin
            pe_tx_valid = 1'b1;
            pe_tx_dst_x = 2'b11;
            pe_tx_dst_y = 2'b11;
            pe_tx_data  = 25'h20 + 25'(i);
            tick();
        end
        pe_tx_valid  = 1'b0;
        net_rx_valid = 1'b1;
        net_rx_pkt   = {2'b01, 2'b10, 2'b10, 2'b00, 25'h33};
        tick();
        net_rx_valid = 1'b0;
        chk("pre_rst_count", 64'(dut.u_fifo.count), 64'd3);
        chk("pre_rst_tx_valid", 64'(net_tx_valid), 64'd1);
        chk("pre_rst_rx_valid", 64'(pe_rx_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_tx_valid", 64'(net_tx_valid), 64'd0);
        chk("async_rx_valid", 64'(pe_rx_valid), 64'd0);
        chk("async_tx_ready", 64'(pe_tx_ready), 64'd0);
        chk("async_rx_ready", 64'(net_rx_ready), 64'd0);
        chk("async_tx_pkt", 64'(net_tx_pkt), 64'd0);
        chk("async_rx_data", 64'(pe_rx_data), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_pre_edge_ready", 64'(net_rx_ready), 64'd0);
        tick();
        chk("rel_tx_ready", 64'(pe_tx_ready), 64'd1);
        chk("rel_rx_ready", 64'(net_rx_ready), 64'd1);
        chk("rel_tx_valid", 64'(net_tx_valid), 64'd0);
        chk("rel_rx_valid", 64'(pe_rx_valid), 64'd0);
        chk("rel_count", 64'(dut.u_fifo.count), 64'd0);
`ifdef NI_STATS_EN
        chk("rel_stat_tx", 64'(tx_count), 64'd0);
        chk("rel_stat_drop", 64'(drop_count), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_net_interface.md
PE_NET_INTERFACE -- requirements
Module: pe_net_interface

Interface
REQ-001 SHALL have parameter WIDTH, default 33, packet width in bits.
REQ-002 SHALL have parameter ADDR_X, default 2'b00, this node's X coordinate.
REQ-003 SHALL have parameter ADDR_Y, default 2'b00, this node's Y coordinate.
REQ-004 SHALL have parameter DEPTH, default 4, TX FIFO entries (power of two, at least 2).
REQ-005 SHALL have port clk, input, 1, sole clock; rising edge active.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports pe_tx_valid (input, 1), pe_tx_ready (output, 1), pe_tx_dst_x (input, 2), pe_tx_dst_y (input, 2), pe_tx_data (input, 25), for PE injection requests.
REQ-008 SHALL have ports net_tx_valid (output, 1), net_tx_ready (input, 1), net_tx_pkt (output, WIDTH), for packets to the router PE input port.
REQ-009 SHALL have ports net_rx_valid (input, 1), net_rx_ready (output, 1), net_rx_pkt (input, WIDTH), for packets from the router PE output port.
REQ-010 SHALL have ports pe_rx_valid (output, 1), pe_rx_ready (input, 1), pe_rx_src_x (output, 2), pe_rx_src_y (output, 2), pe_rx_data (output, 25), for delivery to the PE.

Function
REQ-011 SHALL use packet format [32:31] dst_x, [30:29] dst_y, [28:27] src_x, [26:25] src_y, [24:0] payload.
REQ-012 SHALL transfer on every interface exactly when valid and ready are both high at a rising clk edge; a valid, once raised, stays high with stable data until accepted.
REQ-013 SHALL packetize each accepted PE request as {dst_x, dst_y, ADDR_X, ADDR_Y, data} and push it into the TX FIFO in the same cycle.
REQ-014 SHALL drive pe_tx_ready high iff the FIFO is not full; the ready signal is a registered/combinational function of FIFO state only, not of pe_tx_valid.
REQ-015 SHALL present the FIFO head on net_tx_pkt with net_tx_valid high iff the FIFO is non-empty; push-to-net_tx_valid latency is 1 cycle.
REQ-016 SHALL allow simultaneous push and pop when full, leaving occupancy unchanged only if pe_tx_ready was high, i.e. no push while full.
REQ-017 SHALL wrap read and write pointers modulo DEPTH, and distinguish full from empty with an occupancy counter of width log2(DEPTH)+1.
REQ-018 SHALL keep packets addressed to its own node (dst = ADDR_X/ADDR_Y) on the network path; there is no internal loopback.
REQ-019 SHALL implement RX as a 2-state FSM, EMPTY and FULL, with a 1-entry holding register.
REQ-020 SHALL in EMPTY drive net_rx_ready high; on accept of a packet whose dst matches ADDR_X/ADDR_Y, capture it and go to FULL.
REQ-021 SHALL in EMPTY accept a packet with non-matching dst, drop it, and remain in EMPTY.
REQ-022 SHALL in FULL drive pe_rx_valid high with the src/payload fields of the held packet and net_rx_ready low; on PE accept, go to EMPTY.
REQ-023 SHALL register the delivered fields, so net accept to pe_rx_valid latency is 1 cycle and RX throughput is 1 packet per 2 cycles.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously clear the FIFO pointers and occupancy, set the RX FSM to EMPTY, and drive pe_tx_ready low, net_tx_valid low, pe_rx_valid low, net_rx_ready low, and all data outputs to 0.
REQ-025 SHALL, when reset is asserted mid-transfer, discard all queued and held packets; the first ready is asserted on the first clk edge after rst_n rises.

Configuration
REQ-026 SHALL, when NI_STATS_EN is defined, add 16-bit outputs tx_count, rx_count and drop_count, which count net_tx transfers, pe_rx transfers and dropped misrouted packets; the counters saturate at 16'hFFFF and reset to 0.
REQ-027 SHALL, when NI_STATS_EN is undefined, have neither those ports nor the counter logic.

Structure
REQ-028 SHALL place the packet field offsets, the WIDTH constant, and a packed struct typedef for the packet in a shared package noc_pkg.
REQ-029 SHALL implement the TX queue as a sub-module ni_fifo (parameters WIDTH, DEPTH; valid/ready on both sides).

Verification
REQ-030 SHALL test the following case: with ADDR 01/10, PE sends dst 11/00 with data 25'h1ABCD -> net_tx_pkt = {2'b11, 2'b00, 2'b01, 2'b10, 25'h1ABCD} one cycle later.
REQ-031 SHALL test the following case: with net_tx_ready held low and 5 PE requests -> 4 are accepted, pe_tx_ready is low after the 4th, and release drains them in order.
REQ-032 SHALL test the following case: with ADDR 01/10, net_rx_pkt has dst 01/10, src 00/11 and data 25'h5 -> pe_rx_valid is high next cycle with src 00/11 and data 5, and net_rx_ready stays low until the PE accepts.
REQ-033 SHALL test the following case: net_rx_pkt with dst 10/10 at ADDR 01/10 -> the packet is accepted, pe_rx_valid stays low, and drop_count increments to 1 with NI_STATS_EN.
REQ-034 SHALL test the following case: rst_n pulsed low with 3 packets queued and 1 held -> all valids drop at once, and after release the FIFO is empty and the FSM is in EMPTY.
REQ-035 SHALL test the following case: with the FIFO full, simultaneous net pop and PE push with pe_tx_ready low -> occupancy goes to 3 and the push is not lost, since the PE holds valid and the push completes the next cycle.
